// File: rtl/fse_pkg.sv
// Shared definitions for the FSE bus arbiter: FSM states, bus widths,
// the latched transaction record and the flash/SRAM select helper.
package fse_pkg;

  localparam int FSE_ADDR_W        = 23;
  localparam int FSE_REQ_ADDR_W    = 24;
  localparam int FSE_DATA_W        = 32;
  localparam int FSE_BE_W          = 4;
  localparam int FSE_FLASH_SEL_BIT = 23;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } fse_state_e;

  // Transaction captured at grant time; the port inputs are ignored afterwards.
  typedef struct packed {
    logic                      port;
    logic                      wr;
    logic [FSE_REQ_ADDR_W-1:0] addr;
    logic [FSE_DATA_W-1:0]     wdata;
    logic [FSE_BE_W-1:0]       be;
  } fse_txn_t;

  // Address bit 23 steers the access to flash instead of SRAM.
  function automatic logic fse_is_flash(input logic [FSE_REQ_ADDR_W-1:0] addr);
    return addr[FSE_FLASH_SEL_BIT];
  endfunction

endpackage

// File: rtl/fse_wait_timer.sv
// Loadable down-counter timing the ACCESS phase. A load strobe presets the
// count; it then decrements to zero and stays there. expired flags zero.
module fse_wait_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_r;

  // Preset on load, otherwise count down and hold at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != {CNT_W{1'b0}}) begin
      cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/fse_bus_arbiter.sv
// Two-port arbiter and timing sequencer for the shared Flash-SRAM-Ethernet bus.
// Port 1 (video) has priority over port 0 (CPU). Defining FSE_ARB_STARVE_EN
// adds a starvation counter that forces a port-0 grant after STARVE_LIMIT
// consecutive port-1 grants made while port 0 was waiting.
// All bus and handshake outputs are registered from the next-state decode,
// so each output is valid for the whole cycle of the state it belongs to.
module fse_bus_arbiter
  import fse_pkg::*;
#(
  parameter int SRAM_WAIT  = 1,
  parameter int FLASH_WAIT = 6
`ifdef FSE_ARB_STARVE_EN
  ,
  parameter int STARVE_LIMIT = 8
`endif
) (
  input  logic        clk25MHz,
  input  logic        reset_n,
  input  logic        p0_req,
  input  logic        p0_wr,
  input  logic [23:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [3:0]  p0_be,
  output logic        p0_ack,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_wr,
  input  logic [23:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [3:0]  p1_be,
  output logic        p1_ack,
  output logic [31:0] p1_rdata,
  output logic [22:0] fse_a,
  input  logic [31:0] fse_d_in,
  output logic [31:0] fse_d_out,
  output logic        fse_d_oe,
  output logic        sram_cs_n,
  output logic        flash_cs_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic [3:0]  sram_be_n,
  output logic        enet_aen
);

  localparam int TMR_W = 8;

  fse_state_e        state_r, next_state_s;
  fse_txn_t          txn_r, txn_s;
  logic              grant_s, grant_port_s;
  logic              tmr_load_s, tmr_expired_s;
  logic [TMR_W-1:0]  tmr_val_s;
  logic              active_s, is_flash_s;

  logic [22:0]       fse_a_s;
  logic [31:0]       fse_d_out_s, p0_rdata_s, p1_rdata_s;
  logic              fse_d_oe_s, sram_cs_n_s, flash_cs_n_s;
  logic              sram_oe_n_s, sram_we_n_s, p0_ack_s, p1_ack_s;
  logic [3:0]        sram_be_n_s;

`ifdef FSE_ARB_STARVE_EN
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt_r;
  logic       starve_force_s;

  assign starve_force_s = (starve_cnt_r == STARVE_MAX);
`endif

  // Choose which requesting port wins the IDLE grant
  always_comb begin
    grant_s      = 1'b0;
    grant_port_s = 1'b0;
`ifdef FSE_ARB_STARVE_EN
    if (starve_force_s && p0_req) begin
      grant_s      = 1'b1;
      grant_port_s = 1'b0;
    end else if (p1_req) begin
`else
    if (p1_req) begin
`endif
      grant_s      = 1'b1;
      grant_port_s = 1'b1;
    end else if (p0_req) begin
      grant_s      = 1'b1;
      grant_port_s = 1'b0;
    end else begin
      grant_s      = 1'b0;
      grant_port_s = 1'b0;
    end
  end

`ifdef FSE_ARB_STARVE_EN
  // Count port-1 grants that bypass a waiting port 0
  always_ff @(posedge clk25MHz or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt_r <= 4'd0;
    end else if (state_r == ST_IDLE) begin
      if (!p0_req) begin
        starve_cnt_r <= 4'd0;
      end else if (grant_s && !grant_port_s) begin
        starve_cnt_r <= 4'd0;
      end else if (grant_s && grant_port_s && (starve_cnt_r != 4'hF)) begin
        starve_cnt_r <= starve_cnt_r + 4'd1;
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end
`endif

  // Next-state decode and transaction latch selection
  always_comb begin
    next_state_s = state_r;
    txn_s        = txn_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_s) begin
          next_state_s = ST_SETUP;
          if (grant_port_s) begin
            txn_s = '{port: 1'b1, wr: p1_wr, addr: p1_addr, wdata: p1_wdata, be: p1_be};
          end else begin
            txn_s = '{port: 1'b0, wr: p0_wr, addr: p0_addr, wdata: p0_wdata, be: p0_be};
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_SETUP:  next_state_s = ST_ACCESS;
      ST_ACCESS: begin
        if (tmr_expired_s) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_ACCESS;
        end
      end
      ST_DONE:   next_state_s = ST_IDLE;
      default:   next_state_s = ST_IDLE;
    endcase
  end

  // State and latched transaction registers
  always_ff @(posedge clk25MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      txn_r   <= '{port: 1'b0, wr: 1'b0, addr: 24'h0, wdata: 32'h0, be: 4'h0};
    end else begin
      state_r <= next_state_s;
      txn_r   <= txn_s;
    end
  end

  // Wait timer is preset during SETUP so ACCESS lasts WAIT+1 cycles
  assign tmr_load_s = (state_r == ST_SETUP);
  assign tmr_val_s  = fse_is_flash(txn_r.addr) ? TMR_W'(FLASH_WAIT) : TMR_W'(SRAM_WAIT);

  fse_wait_timer #(
    .CNT_W(TMR_W)
  ) u_wait_timer (
    .clk      (clk25MHz),
    .rst_n    (reset_n),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .expired  (tmr_expired_s)
  );

  // Bus pin and handshake values for the state being entered
  always_comb begin
    active_s   = (next_state_s == ST_SETUP) || (next_state_s == ST_ACCESS);
    is_flash_s = fse_is_flash(txn_s.addr);

    fse_a_s     = fse_a;
    fse_d_out_s = fse_d_out;
    if (next_state_s == ST_SETUP) begin
      fse_a_s     = txn_s.addr[FSE_ADDR_W-1:0];
      fse_d_out_s = txn_s.wr ? txn_s.wdata : fse_d_out;
    end else begin
      fse_a_s     = fse_a;
      fse_d_out_s = fse_d_out;
    end

    fse_d_oe_s   = active_s && txn_s.wr;
    sram_cs_n_s  = !(active_s && !is_flash_s);
    flash_cs_n_s = !(active_s && is_flash_s);
    sram_oe_n_s  = !((next_state_s == ST_ACCESS) && !txn_s.wr);
    sram_we_n_s  = !((next_state_s == ST_ACCESS) && txn_s.wr);
    if (active_s) begin
      sram_be_n_s = txn_s.wr ? ~txn_s.be : 4'h0;
    end else begin
      sram_be_n_s = 4'hF;
    end

    p0_ack_s = (next_state_s == ST_DONE) && !txn_s.port;
    p1_ack_s = (next_state_s == ST_DONE) && txn_s.port;

    // Read data is taken on the final ACCESS edge; writes leave rdata alone
    p0_rdata_s = p0_rdata;
    p1_rdata_s = p1_rdata;
    if ((state_r == ST_ACCESS) && tmr_expired_s && !txn_r.wr) begin
      if (txn_r.port) begin
        p1_rdata_s = fse_d_in;
      end else begin
        p0_rdata_s = fse_d_in;
      end
    end else begin
      p0_rdata_s = p0_rdata;
      p1_rdata_s = p1_rdata;
    end
  end

  // Output registers; reset drops any in-flight transaction without an ack
  always_ff @(posedge clk25MHz or negedge reset_n) begin
    if (!reset_n) begin
      fse_a      <= 23'h0;
      fse_d_out  <= 32'h0;
      fse_d_oe   <= 1'b0;
      sram_cs_n  <= 1'b1;
      flash_cs_n <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_be_n  <= 4'hF;
      enet_aen   <= 1'b1;
      p0_ack     <= 1'b0;
      p1_ack     <= 1'b0;
      p0_rdata   <= 32'h0;
      p1_rdata   <= 32'h0;
    end else begin
      fse_a      <= fse_a_s;
      fse_d_out  <= fse_d_out_s;
      fse_d_oe   <= fse_d_oe_s;
      sram_cs_n  <= sram_cs_n_s;
      flash_cs_n <= flash_cs_n_s;
      sram_oe_n  <= sram_oe_n_s;
      sram_we_n  <= sram_we_n_s;
      sram_be_n  <= sram_be_n_s;
      enet_aen   <= 1'b1;
      p0_ack     <= p0_ack_s;
      p1_ack     <= p1_ack_s;
      p0_rdata   <= p0_rdata_s;
      p1_rdata   <= p1_rdata_s;
    end
  end

endmodule

// File: tb/tb_fse_bus_arbiter.sv
// Directed self-checking bench for fse_bus_arbiter (default waits: SRAM 1,
// flash 6). Cycle c counts clock edges after the request is set up in IDLE.
module tb_fse_bus_arbiter;

  logic        clk25MHz = 1'b0;
  logic        reset_n;
  logic        p0_req, p0_wr, p1_req, p1_wr;
  logic [23:0] p0_addr, p1_addr;
  logic [31:0] p0_wdata, p1_wdata;
  logic [3:0]  p0_be, p1_be;
  logic        p0_ack, p1_ack;
  logic [31:0] p0_rdata, p1_rdata;
  logic [22:0] fse_a;
  logic [31:0] fse_d_in, fse_d_out;
  logic        fse_d_oe, sram_cs_n, flash_cs_n, sram_oe_n, sram_we_n, enet_aen;
  logic [3:0]  sram_be_n;

  int checks   = 0;
  int failures = 0;

  always #20 clk25MHz = ~clk25MHz;

  fse_bus_arbiter dut (
    .clk25MHz(clk25MHz), .reset_n(reset_n),
    .p0_req(p0_req), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_be(p0_be),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_be(p1_be),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .fse_a(fse_a), .fse_d_in(fse_d_in), .fse_d_out(fse_d_out), .fse_d_oe(fse_d_oe),
    .sram_cs_n(sram_cs_n), .flash_cs_n(flash_cs_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_be_n(sram_be_n), .enet_aen(enet_aen)
  );

  task automatic tick();
    @(posedge clk25MHz);
    #1;
  endtask

  task automatic idle_inputs();
    p0_req = 1'b0; p0_wr = 1'b0; p0_addr = 24'h0; p0_wdata = 32'h0; p0_be = 4'h0;
    p1_req = 1'b0; p1_wr = 1'b0; p1_addr = 24'h0; p1_wdata = 32'h0; p1_be = 4'h0;
  endtask

  task automatic test_reset();
    logic [11:0] ctl;
    reset_n = 1'b0;
    idle_inputs();
    fse_d_in = 32'h0;
    repeat (3) tick();
    ctl = {sram_cs_n, flash_cs_n, sram_oe_n, sram_we_n, sram_be_n, enet_aen, fse_d_oe, p0_ack, p1_ack};
    checks++;
    if (ctl !== 12'b1111_1111_1000) begin
      failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 12'b1111_1111_1000);
    end
    checks++;
    if ({fse_a, fse_d_out} !== 55'h0) begin
      failures++; $display("FAIL reset_bus got=%h/%h exp=0/0", fse_a, fse_d_out);
    end
    checks++;
    if ({p0_rdata, p1_rdata} !== 64'h0) begin
      failures++; $display("FAIL reset_rdata got=%h/%h exp=0/0", p0_rdata, p1_rdata);
    end
    reset_n = 1'b1;
    repeat (2) tick();
    checks++;
    if ({sram_cs_n, flash_cs_n, p0_ack, p1_ack} !== 4'b1100) begin
      failures++; $display("FAIL idle_after_reset got=%b exp=1100", {sram_cs_n, flash_cs_n, p0_ack, p1_ack});
    end
  endtask

  task automatic test_sram_read();
    logic exp_cs, exp_oe, exp_ack;
    fse_d_in = 32'hDEADBEEF;
    p0_addr = 24'h000010; p0_wr = 1'b0; p0_req = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      exp_cs  = (c <= 3) ? 1'b0 : 1'b1;
      exp_oe  = (c == 2 || c == 3) ? 1'b0 : 1'b1;
      exp_ack = (c == 4) ? 1'b1 : 1'b0;
      checks++;
      if ({sram_cs_n, flash_cs_n, sram_oe_n, sram_we_n} !== {exp_cs, 1'b1, exp_oe, 1'b1}) begin
        failures++;
        $display("FAIL sram_read_strobes c=%0d got=%b exp=%b", c,
                 {sram_cs_n, flash_cs_n, sram_oe_n, sram_we_n}, {exp_cs, 1'b1, exp_oe, 1'b1});
      end
      checks++;
      if ({p0_ack, p1_ack} !== {exp_ack, 1'b0}) begin
        failures++; $display("FAIL sram_read_ack c=%0d got=%b exp=%b", c, {p0_ack, p1_ack}, {exp_ack, 1'b0});
      end
      if (c <= 3) begin
        checks++;
        if (fse_a !== 23'h000010) begin
          failures++; $display("FAIL sram_read_addr c=%0d got=%h exp=000010", c, fse_a);
        end
      end
      if (c == 4) begin
        checks++;
        if (p0_rdata !== 32'hDEADBEEF) begin
          failures++; $display("FAIL sram_read_data got=%h exp=deadbeef", p0_rdata);
        end
        p0_req = 1'b0;
      end
    end
  endtask

  task automatic test_sram_write();
    logic [3:0] exp_be;
    logic       exp_we, exp_oe_d;
    int         acks = 0;
    fse_d_in = 32'h55AA55AA;
    p1_addr = 24'h000020; p1_wr = 1'b1; p1_wdata = 32'h12345678; p1_be = 4'b0011; p1_req = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      exp_be   = (c <= 3) ? 4'b1100 : 4'b1111;
      exp_we   = (c == 2 || c == 3) ? 1'b0 : 1'b1;
      exp_oe_d = (c <= 3) ? 1'b1 : 1'b0;
      checks++;
      if ({sram_be_n, sram_we_n, sram_oe_n, fse_d_oe} !== {exp_be, exp_we, 1'b1, exp_oe_d}) begin
        failures++;
        $display("FAIL sram_write_ctl c=%0d got=%b exp=%b", c,
                 {sram_be_n, sram_we_n, sram_oe_n, fse_d_oe}, {exp_be, exp_we, 1'b1, exp_oe_d});
      end
      if (c <= 3) begin
        checks++;
        if (fse_d_out !== 32'h12345678) begin
          failures++; $display("FAIL sram_write_data c=%0d got=%h exp=12345678", c, fse_d_out);
        end
      end
      if (p1_ack === 1'b1) acks++;
      if (c == 4) begin
        checks++;
        if (p1_ack !== 1'b1) begin
          failures++; $display("FAIL sram_write_ack_cycle got=%b exp=1", p1_ack);
        end
        p1_req = 1'b0;
      end
    end
    checks++;
    if (acks != 1) begin
      failures++; $display("FAIL sram_write_ack_count got=%0d exp=1", acks);
    end
    checks++;
    if ({p0_rdata, p1_rdata} !== {32'hDEADBEEF, 32'h0}) begin
      failures++; $display("FAIL write_rdata_hold got=%h/%h exp=deadbeef/00000000", p0_rdata, p1_rdata);
    end
  endtask

  task automatic test_flash_read();
    logic exp_fcs, exp_oe, exp_ack;
    fse_d_in = 32'hCAFEF00D;
    p0_addr = 24'h800004; p0_wr = 1'b0; p0_req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      exp_fcs = (c <= 8) ? 1'b0 : 1'b1;
      exp_oe  = (c >= 2 && c <= 8) ? 1'b0 : 1'b1;
      exp_ack = (c == 9) ? 1'b1 : 1'b0;
      checks++;
      if ({flash_cs_n, sram_cs_n, sram_oe_n, p0_ack} !== {exp_fcs, 1'b1, exp_oe, exp_ack}) begin
        failures++;
        $display("FAIL flash_read_ctl c=%0d got=%b exp=%b", c,
                 {flash_cs_n, sram_cs_n, sram_oe_n, p0_ack}, {exp_fcs, 1'b1, exp_oe, exp_ack});
      end
      if (c <= 8) begin
        checks++;
        if (fse_a !== 23'h000004) begin
          failures++; $display("FAIL flash_read_addr c=%0d got=%h exp=000004", c, fse_a);
        end
      end
      if (c == 9) begin
        checks++;
        if (p0_rdata !== 32'hCAFEF00D) begin
          failures++; $display("FAIL flash_read_data got=%h exp=cafef00d", p0_rdata);
        end
        p0_req = 1'b0;
      end
    end
  endtask

  task automatic test_back_to_back();
    int n = 0, p0_cnt = 0, seq_errs = 0, first_c = 0, last_c = 0, exp_p0_cnt;
    logic exp_p0;
`ifdef FSE_ARB_STARVE_EN
    exp_p0_cnt = 5;
`else
    exp_p0_cnt = 0;
`endif
    fse_d_in = 32'h11112222;
    p0_addr = 24'h000100; p0_wr = 1'b0;
    p1_addr = 24'h000200; p1_wr = 1'b0;
    p0_req = 1'b1; p1_req = 1'b1;
    for (int c = 1; c <= 250; c++) begin
      tick();
      if (p0_ack === 1'b1 && p1_ack === 1'b1) seq_errs++;
      if (p0_ack === 1'b1 || p1_ack === 1'b1) begin
        n++;
`ifdef FSE_ARB_STARVE_EN
        exp_p0 = ((n % 9) == 0) ? 1'b1 : 1'b0;
`else
        exp_p0 = 1'b0;
`endif
        if (p0_ack !== exp_p0) seq_errs++;
        if (p0_ack === 1'b1) p0_cnt++;
        if (n == 1) first_c = c;
        last_c = c;
      end
    end
    p0_req = 1'b0; p1_req = 1'b0;
    checks++;
    if (n != 50) begin
      failures++; $display("FAIL b2b_count got=%0d exp=50", n);
    end
    checks++;
    if (p0_cnt != exp_p0_cnt) begin
      failures++; $display("FAIL b2b_p0_grants got=%0d exp=%0d", p0_cnt, exp_p0_cnt);
    end
    checks++;
    if (seq_errs != 0) begin
      failures++; $display("FAIL b2b_order got=%0d errors exp=0", seq_errs);
    end
    checks++;
    if (first_c != 4 || last_c != 249) begin
      failures++; $display("FAIL b2b_timing got=%0d..%0d exp=4..249", first_c, last_c);
    end
    repeat (3) tick();
  endtask

  task automatic test_reset_mid_access();
    logic [11:0] ctl;
    int          acks = 0;
    fse_d_in = 32'h0BADCAFE;
    p0_addr = 24'h800008; p0_wr = 1'b0; p0_req = 1'b1;
    repeat (3) tick();
    checks++;
    if ({flash_cs_n, sram_oe_n} !== 2'b00) begin
      failures++; $display("FAIL mid_access_pre got=%b exp=00", {flash_cs_n, sram_oe_n});
    end
    #5 reset_n = 1'b0;
    #1;
    ctl = {sram_cs_n, flash_cs_n, sram_oe_n, sram_we_n, sram_be_n, enet_aen, fse_d_oe, p0_ack, p1_ack};
    checks++;
    if (ctl !== 12'b1111_1111_1000) begin
      failures++; $display("FAIL async_reset_ctl got=%b exp=%b", ctl, 12'b1111_1111_1000);
    end
    checks++;
    if ({fse_a, p0_rdata} !== 55'h0) begin
      failures++; $display("FAIL async_reset_bus got=%h/%h exp=0/0", fse_a, p0_rdata);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      if (p0_ack !== 1'b0) acks++;
    end
    reset_n = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (p0_ack === 1'b1 && c != 9) acks++;
      if (c == 1) begin
        checks++;
        if (flash_cs_n !== 1'b0) begin
          failures++; $display("FAIL post_reset_restart got=%b exp=0", flash_cs_n);
        end
      end
      if (c == 9) begin
        checks++;
        if ({p0_ack, p0_rdata} !== {1'b1, 32'h0BADCAFE}) begin
          failures++; $display("FAIL post_reset_done got=%b/%h exp=1/0badcafe", p0_ack, p0_rdata);
        end
        p0_req = 1'b0;
      end
    end
    checks++;
    if (acks != 0) begin
      failures++; $display("FAIL reset_spurious_ack got=%0d exp=0", acks);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    fse_d_in = 32'h0;
    test_reset();
    test_sram_read();
    test_sram_write();
    test_flash_read();
    test_back_to_back();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fse_bus_arbiter.md
# fse_bus_arbiter

Arbiter and timing sequencer for the shared Flash-SRAM-Ethernet (FSE) bus. It accepts word transactions from two requesters, port 0 (CPU) and port 1 (video fetch), and grants one at a time. It drives the SRAM and flash chip selects, strobes and wait states, and returns read data with a one-cycle acknowledge. It sits between the system core and the board pins; the top level builds the `fse_d` tristate from `fse_d_out`/`fse_d_oe`.

## Interface
- `SRAM_WAIT`, 1: extra ACCESS cycles for SRAM (ACCESS lasts SRAM_WAIT+1 cycles).
- `FLASH_WAIT`, 6: extra ACCESS cycles for flash.
- `STARVE_LIMIT`, 8: consecutive port-1 grants while port 0 waits before port 0 is forced (only with `FSE_ARB_STARVE_EN`).

- `clk25MHz` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `p0_req`, `p1_req` in 1: transaction request, held until ack.
- `p0_wr`, `p1_wr` in 1: 1 = write.
- `p0_addr`, `p1_addr` in 24: word address; bit 23 = 1 selects flash, 0 selects SRAM.
- `p0_wdata`, `p1_wdata` in 32: write data.
- `p0_be`, `p1_be` in 4: active-high byte enables for writes.
- `p0_ack`, `p1_ack` out 1: one-cycle completion pulse.
- `p0_rdata`, `p1_rdata` out 32: read data, valid during ack.
- `fse_a` out 23: bus address (`addr[22:0]`).
- `fse_d_in` in 32: bus data from pins.
- `fse_d_out` out 32: bus data to pins.
- `fse_d_oe` out 1: data pin drive enable.
- `sram_cs_n`, `flash_cs_n` out 1: chip selects.
- `sram_oe_n`, `sram_we_n` out 1: shared read and write strobes (also used by flash).
- `sram_be_n` out 4: byte enables, active low.
- `enet_aen` out 1: held 1 (Ethernet never accessed).

## Operation
- The FSM has four states: IDLE → SETUP → ACCESS → DONE → IDLE.
- **IDLE**
  - Samples requests.
  - Default priority is port 1 over port 0.
  - If neither port requests, stays in IDLE.
  - On a grant, latches the port number, `wr`, `addr`, `wdata` and `be`. Later changes on the port inputs are ignored until that port's ack.
- **SETUP** (1 cycle)
  - Drives `fse_a` and asserts the selected `cs_n` (by addr[23]).
  - Strobes stay high.
  - Writes: `fse_d_oe`=1 with `fse_d_out`=wdata, and `sram_be_n`=~be.
  - Reads: `sram_be_n`=0.
- **ACCESS** (WAIT+1 cycles)
  - A wait counter loads SRAM_WAIT or FLASH_WAIT and counts down to 0.
  - Reads hold `oe_n`=0; writes hold `we_n`=0.
  - Read data is captured from `fse_d_in` on the last ACCESS edge.
- **DONE** (1 cycle)
  - All strobes and selects are high and `fse_d_oe`=0, giving bus turnaround.
  - The granted port's ack=1 and its rdata holds the captured word.
  - On a write, rdata is unchanged.
- Each rdata register holds its value until that port's next read completes.
- Address, be and data stay stable from SETUP through ACCESS.
- A new request present during DONE is considered only in the following IDLE cycle.
- Simultaneous requests are resolved by priority (see Configuration). The losing port waits with its request held.

## Timing
- Reset values:
  - all `*_cs_n`, `sram_oe_n`, `sram_we_n` = 1
  - `sram_be_n` = 4'hF
  - `enet_aen` = 1
  - `fse_a` = 0, `fse_d_out` = 0, `fse_d_oe` = 0
  - acks = 0, rdata = 0
  - state = IDLE
- Outputs are registered.
- Latency from request sampled in IDLE (cycle 0) to ack is 3+WAIT cycles:
  - SRAM with defaults: ack in cycle 4.
  - Flash with defaults: ack in cycle 9.
- Back-to-back throughput is one transaction per 4+WAIT cycles.
- Reset asserted mid-transaction: outputs return to reset values asynchronously, the transaction is dropped and no ack is issued. After reset, the FSM restarts in IDLE.

## Configuration
- `FSE_ARB_STARVE_EN` defined:
  - A 4-bit starvation counter increments on each port-1 grant made while `p0_req` is high.
  - When the counter equals STARVE_LIMIT, the next IDLE grant goes to port 0.
  - The counter clears on any port-0 grant, or in IDLE when `p0_req`=0.
- `FSE_ARB_STARVE_EN` undefined: strict priority to port 1, and no counter logic.

## Structure
- Package `fse_pkg` holds:
  - FSM state enum
  - `FSE_FLASH_SEL_BIT` = 23
  - bus widths (address 23, data 32, be 4)
- Sub-module `fse_wait_timer` is a loadable down-counter. It takes a load value and load strobe and outputs `expired`. The arbiter uses it for the ACCESS duration.

## Test plan
- **SRAM read, port 0 only:** addr 0x000010, `fse_d_in`=0xDEADBEEF.
  - `sram_cs_n` low cycles 1–3, `oe_n` low cycles 2–3.
  - `p0_ack` in cycle 4 with rdata=0xDEADBEEF.
- **SRAM write, port 1:** be=4'b0011, wdata=0x12345678.
  - `sram_be_n`=4'b1100, `we_n` low 2 cycles, `fse_d_oe` high only in SETUP/ACCESS.
  - Single `p1_ack`.
- **Flash read:** addr 0x800004.
  - `flash_cs_n` low, `sram_cs_n` high throughout, `fse_a`=0x000004.
  - Ack in cycle 9.
- **Both ports requesting continuously, macro off:** port 0 is never acked over 50 transactions.
- **Both ports requesting continuously, macro on:** port 0 is granted after every 8 port-1 grants.
- **Reset pulsed during ACCESS:** all strobes high immediately and no ack. After reset release, a pending request completes normally.
